// File: rtl/vga_reg_snapshot.sv
`default_nettype none
// ============================================================================
// Module   : vga_reg_snapshot
// Purpose  : Frame-coherent capture of the CPU debug register file for the
//            VGA debug screen. On each vsync assertion edge, every CPU
//            register is copied sequentially into a local buffer. The display
//            reads that buffer combinationally with zero latency.
// Options  : VGA_SNAP_DBUF_EN defined   -> double-buffered (back bank is
//                                          filled, then swapped to the front)
//            VGA_SNAP_DBUF_EN undefined -> single bank, written in place
// Revision : 1.0 - initial release
// ============================================================================
module vga_reg_snapshot #(
    parameter int REG_NUM   = 32,   // registers captured, 2..32
    parameter bit VSYNC_POL = 1'b0  // active level of vsync
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        freeze,
    output logic [4:0]  cpu_regAddr,
    input  logic [31:0] cpu_regData,
    input  logic [4:0]  regAddr,
    output logic [31:0] regData,
    output logic        busy,
    output logic [7:0]  frame_cnt
);

    // Index width for the storage arrays, and the last index captured.
    localparam int         c_AW   = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [4:0] c_LAST = 5'(REG_NUM - 1);
    localparam logic [5:0] c_NUM  = 6'(REG_NUM);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SWAP    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_vs_q;
    logic [4:0]        r_idx;
    logic [7:0]        r_frame_cnt;
    logic              w_start;
    logic              w_capture;
    logic              w_swap;
    logic              w_rd_ok;
    logic [c_AW-1:0]   w_wr_idx;
    logic [c_AW-1:0]   w_rd_idx;

    // A capture is triggered only by the inactive-to-active vsync transition.
    assign w_start  = (vsync == VSYNC_POL) && (r_vs_q != VSYNC_POL);

    // Display addresses beyond the captured range read as zero.
    assign w_rd_ok  = ({1'b0, regAddr} < c_NUM);
    assign w_wr_idx = r_idx[c_AW-1:0];
    assign w_rd_idx = regAddr[c_AW-1:0];

    assign frame_cnt = r_frame_cnt;

    // Delay vsync by one clock for edge detection; resets to the inactive level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vs_q <= ~VSYNC_POL;
        end else begin
            r_vs_q <= vsync;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and output decode; starts during capture/swap are dropped.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_swap       = 1'b0;
        busy         = 1'b0;
        cpu_regAddr  = 5'd0;
        case (r_state)
            S_IDLE: begin
                if (w_start && !freeze) begin
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                busy        = 1'b1;
                w_capture   = 1'b1;
                cpu_regAddr = r_idx;
                if (r_idx == c_LAST) begin
                    w_state_next = S_SWAP;
                end
            end
            S_SWAP: begin
                busy         = 1'b1;
                w_swap       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Capture index walks 0..REG_NUM-1 and sits at 0 outside of CAPTURE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= 5'd0;
        end else if (w_capture && (r_idx != c_LAST)) begin
            r_idx <= r_idx + 5'd1;
        end else begin
            r_idx <= 5'd0;
        end
    end

    // Completed-snapshot counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= 8'd0;
        end else if (w_swap) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

`ifdef VGA_SNAP_DBUF_EN
    // Two banks; r_front picks the displayed one, the other is filled.
    logic [31:0] r_bank0 [0:REG_NUM-1];
    logic [31:0] r_bank1 [0:REG_NUM-1];
    logic        r_front;

    // Front-bank select flips only on a completed capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_front <= 1'b0;
        end else if (w_swap) begin
            r_front <= ~r_front;
        end
    end

    // Bank 0 is the write target while bank 1 is displayed.
    always_ff @(posedge clk) begin
        if (w_capture && r_front) begin
            r_bank0[w_wr_idx] <= cpu_regData;
        end
    end

    // Bank 1 is the write target while bank 0 is displayed.
    always_ff @(posedge clk) begin
        if (w_capture && !r_front) begin
            r_bank1[w_wr_idx] <= cpu_regData;
        end
    end

    // Zero-latency display read of the front bank.
    always_comb begin
        regData = 32'd0;
        if (w_rd_ok) begin
            regData = r_front ? r_bank1[w_rd_idx] : r_bank0[w_rd_idx];
        end
    end
`else
    // Single bank written in place; the display may see a mixed frame.
    logic [31:0] r_bank [0:REG_NUM-1];

    // Capture writes straight into the displayed bank.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_bank[w_wr_idx] <= cpu_regData;
        end
    end

    // Zero-latency display read of the only bank.
    always_comb begin
        regData = 32'd0;
        if (w_rd_ok) begin
            regData = r_bank[w_rd_idx];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_reg_snapshot.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_reg_snapshot
// Purpose  : Self-checking bench for vga_reg_snapshot (REG_NUM=32,
//            active-low vsync). Snapshot completions are checked by a
//            monitor against a queue of expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_reg_snapshot;

    logic        clk;
    logic        reset;
    logic        vsync;
    logic        freeze;
    logic [4:0]  cpu_regAddr;
    logic [31:0] cpu_regData;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic [31:0] cpu_base;

    int checks;
    int errors;

    typedef struct {
        logic [7:0]  cnt;
        logic [31:0] data;
        int          len;
    } exp_t;

    exp_t sb_q[$];

    vga_reg_snapshot dut (
        .clk         (clk),
        .reset       (reset),
        .vsync       (vsync),
        .freeze      (freeze),
        .cpu_regAddr (cpu_regAddr),
        .cpu_regData (cpu_regData),
        .regAddr     (regAddr),
        .regData     (regData),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    // CPU register file model: reg[i] = base + i, combinational read.
    assign cpu_regData = cpu_base + {27'd0, cpu_regAddr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] cnt, input logic [31:0] data);
        exp_t e;
        e.cnt  = cnt;
        e.data = data;
        e.len  = 33;
        sb_q.push_back(e);
    endtask

    // Monitor: a busy falling edge marks a finished snapshot.
    initial begin : monitor
        int   run;
        logic prev;
        exp_t e;
        run  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                run  = 0;
                prev = 1'b0;
            end else begin
                if (busy) begin
                    run++;
                end else if (prev) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_snapshot", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("snap_busy_len", 32'(run), 32'(e.len));
                        chk("snap_frame_cnt", 32'(frame_cnt), 32'(e.cnt));
                        chk("snap_regData", regData, e.data);
                    end
                    run = 0;
                end
                prev = busy;
            end
        end
    end

    task automatic pulse_vsync();
        @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        vsync = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!busy) begin
            chk({tag, "_start_timeout"}, 32'd0, 32'd1);
            return;
        end
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({tag, "_done_timeout"}, 32'd1, 32'd0);
        @(negedge clk);
    endtask

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin : stim
        logic seen;
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        vsync    = 1'b1;
        freeze   = 1'b0;
        regAddr  = 5'd0;
        cpu_base = 32'd0;

        // Reset state, then 100 idle cycles with vsync inactive.
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_cpu_regAddr", 32'(cpu_regAddr), 32'd0);
            chk("idle_frame_cnt", 32'(frame_cnt), 32'd0);
        end

        // First snapshot.
        cpu_base = 32'hA5A5_0000;
        regAddr  = 5'd7;
        push_exp(8'd1, 32'hA5A5_0007);
        pulse_vsync();
        wait_done("snap1");
        regAddr = 5'd31;
        #1 chk("snap1_reg31", regData, 32'hA5A5_001F);

        // Second snapshot, observed cycle by cycle from the start edge.
        cpu_base = 32'h1234_0000;
        regAddr  = 5'd3;
        push_exp(8'd2, 32'h1234_0003);
        @(negedge clk);
        vsync = 1'b0;
        @(posedge clk);
        #1;
        chk("s2_k0_busy", 32'(busy), 32'd1);
        chk("s2_k0_regData", regData, 32'hA5A5_0003);
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) vsync = 1'b1;
            if (k == 3) chk("s2_k3_regData", regData, 32'hA5A5_0003);
            if (k == 5) chk("s2_k5_cpu_regAddr", 32'(cpu_regAddr), 32'd5);
`ifdef VGA_SNAP_DBUF_EN
            if (k == 4)  chk("s2_k4_regData", regData, 32'hA5A5_0003);
            if (k == 32) chk("s2_k32_regData", regData, 32'hA5A5_0003);
`else
            if (k == 4)  chk("s2_k4_regData", regData, 32'h1234_0003);
            if (k == 32) chk("s2_k32_regData", regData, 32'h1234_0003);
`endif
            if (k == 32) chk("s2_k32_busy", 32'(busy), 32'd1);
            if (k == 33) begin
                chk("s2_k33_regData", regData, 32'h1234_0003);
                chk("s2_k33_busy", 32'(busy), 32'd0);
                chk("s2_k33_frame_cnt", 32'(frame_cnt), 32'd2);
            end
        end
        repeat (3) @(negedge clk);

        // Frozen vsync edge: no capture, no retry after freeze drops.
        freeze = 1'b1;
        seen   = 1'b0;
        @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        freeze = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
            if (i == 3) vsync = 1'b1;
        end
        chk("freeze_busy_seen", 32'(seen), 32'd0);
        chk("freeze_frame_cnt", 32'(frame_cnt), 32'd2);

        // Second vsync and a freeze rise during capture: one snapshot only.
        cpu_base = 32'hCAFE_0000;
        regAddr  = 5'd5;
        push_exp(8'd3, 32'hCAFE_0005);
        pulse_vsync();
        repeat (2) @(negedge clk);
        pulse_vsync();
        freeze = 1'b1;
        wait_done("snap3");
        freeze = 1'b0;
        repeat (50) @(negedge clk);
        chk("double_vsync_frame_cnt", 32'(frame_cnt), 32'd3);

        // Reset at capture cycle 10 aborts without a swap.
        cpu_base = 32'h0BAD_0000;
        regAddr  = 5'd20;
        @(negedge clk);
        vsync = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vsync = 1'b1;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("abort_cpu_regAddr", 32'(cpu_regAddr), 32'd0);
`ifdef VGA_SNAP_DBUF_EN
        chk("abort_front0_regData", regData, 32'h1234_0014);
`else
        chk("abort_front0_regData", regData, 32'hCAFE_0014);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cpu_base = 32'h7777_0000;
        push_exp(8'd1, 32'h7777_0014);
        pulse_vsync();
        wait_done("after_abort");

        // 256 snapshots from reset: counter wraps back to 0.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("wrap_start_cnt", 32'(frame_cnt), 32'd0);
        regAddr = 5'd9;
        for (int i = 0; i < 256; i++) begin
            cpu_base = {16'(i), 16'h0000};
            push_exp(8'(i + 1), {16'(i), 16'h0009});
            pulse_vsync();
            wait_done("wrap");
        end
        chk("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
